// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction-fetch front end.
package fetch_unit_pkg;
   localparam int INSTR_LEN   = 32;
   localparam int WORD        = 64;
   localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/fetch_queue.sv
// Small power-of-two FIFO of {pc, instr} entries between instr_mem and decode.
module fetch_queue #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 96
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    head_q, tail_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == FULL_CNT);
   assign count_o = count_q;
   assign rdata_o = mem_q[head_q];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Reset clears the stored entries so the head reads as zero afterwards.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (flush_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[tail_q] <= wdata_i;
            tail_q        <= tail_q + 1'b1;
         end
         if (do_pop) head_q <= head_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, tracks the single in-flight instr_mem read,
// and feeds decode from a small queue; redirects flush everything pending.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                  PC_WIDTH = 64,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
   parameter int                  QDEPTH   = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic                 imem_req,
   output logic [PC_WIDTH-1:0]  imem_addr,
   input  logic [INSTR_LEN-1:0] imem_instr,
   input  logic                 redirect,
   input  logic [PC_WIDTH-1:0]  redirect_pc,
   output logic                 f_valid,
   input  logic                 f_ready,
   output logic [INSTR_LEN-1:0] f_instr,
   output logic [PC_WIDTH-1:0]  f_pc
);
   localparam int CW = $clog2(QDEPTH) + 1;
   localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
   logic                inflight_q, inflight_d;
   logic [CW-1:0]       count;
   logic [CW:0]         occupancy;
   logic                q_empty, q_full;
   logic                pop, push, issue;

   assign pop = f_valid && f_ready;
   // Slots committed after this edge: queued + returning - leaving.
   assign occupancy = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
   assign issue     = !reset && !redirect && (occupancy < (CW+1)'(QDEPTH));
   assign push      = inflight_q && !redirect && (!q_full || pop);

   assign imem_req  = issue;
   assign imem_addr = pc_q;
   assign f_valid   = !q_empty;

   always_comb begin
      pc_d          = pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      if (redirect) begin
         pc_d = redirect_pc & ALIGN_MASK;
      end else if (issue) begin
         pc_d          = pc_q + PC_WIDTH'(INSTR_BYTES);
         inflight_d    = 1'b1;
         inflight_pc_d = pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         inflight_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
      end
   end

   // Tag only matters while inflight_q is set, so it needs no reset.
   always_ff @(posedge clk) begin
      inflight_pc_q <= inflight_pc_d;
   end

   fetch_queue #(
      .DEPTH (QDEPTH),
      .WIDTH (PC_WIDTH + INSTR_LEN)
   ) u_queue (
      .clk_i   (clk),
      .reset_i (reset),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (redirect),
      .wdata_i ({inflight_pc_q, imem_instr}),
      .rdata_o ({f_pc, f_instr}),
      .full_o  (q_full),
      .empty_o (q_empty),
      .count_o (count)
   );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle-latency instr_mem model.
module tb_fetch_unit;
   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic        f_valid;
   logic        f_ready;
   logic [31:0] f_instr;
   logic [63:0] f_pc;

   int checks = 0;
   int errors = 0;

   fetch_unit #(.PC_WIDTH(64), .RESET_PC(64'h0), .QDEPTH(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_instr  (imem_instr),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .f_valid     (f_valid),
      .f_ready     (f_ready),
      .f_instr     (f_instr),
      .f_pc        (f_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return 32'hA000_0000 + a[33:2];
   endfunction

   always @(posedge clk) imem_instr <= mem_word(imem_addr);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rst;
      logic        rdr;
      logic [63:0] rpc;
      logic        rdy;
      logic        e_req;
      logic [63:0] e_addr;
      logic        e_vld;
      logic        hd;
      logic [63:0] e_pc;
   } vec_t;

   vec_t tbl[$];

   function automatic void v(input logic rst, input logic rdr, input logic [63:0] rpc,
                             input logic rdy, input logic e_req, input logic [63:0] e_addr,
                             input logic e_vld, input logic hd, input logic [63:0] e_pc);
      vec_t r;
      r.rst = rst; r.rdr = rdr; r.rpc = rpc; r.rdy = rdy; r.e_req = e_req;
      r.e_addr = e_addr; r.e_vld = e_vld; r.hd = hd; r.e_pc = e_pc;
      tbl.push_back(r);
   endfunction

   initial begin
      int q, inf, pops, wait_cnt;
      logic [63:0] exp_pc;
      logic exp_req, popped;

      reset = 1'b1; redirect = 1'b0; redirect_pc = '0; f_ready = 1'b1;

      //  rst rdr rpc        rdy req addr        vld hd pc
      v(1, 0, 64'h0,   1, 0, 64'h0,   0, 1, 64'h0);    // reset state, head cleared
      v(0, 0, 64'h0,   1, 1, 64'h0,   0, 0, 64'h0);    // first issue
      v(0, 0, 64'h0,   1, 1, 64'h4,   0, 0, 64'h0);
      v(0, 0, 64'h0,   1, 1, 64'h8,   1, 1, 64'h0);    // valid 2 cycles after release
      v(0, 0, 64'h0,   1, 1, 64'hC,   1, 1, 64'h4);
      v(0, 0, 64'h0,   1, 1, 64'h10,  1, 1, 64'h8);
      for (int i = 0; i < 5; i++)
         v(0, 0, 64'h0, 0, 0, 64'h14, 1, 1, 64'hC);    // backpressure: head held
      v(0, 0, 64'h0,   1, 1, 64'h14,  1, 1, 64'hC);
      v(0, 0, 64'h0,   1, 1, 64'h18,  1, 1, 64'h10);
      v(0, 0, 64'h0,   1, 1, 64'h1C,  1, 1, 64'h14);
      v(0, 0, 64'h0,   1, 1, 64'h20,  1, 1, 64'h18);
      v(0, 1, 64'h100, 0, 0, 64'h24,  1, 1, 64'h1C);   // redirect with fetch in flight
      v(0, 0, 64'h0,   1, 1, 64'h100, 0, 0, 64'h0);
      v(0, 0, 64'h0,   1, 1, 64'h104, 0, 0, 64'h0);
      v(0, 0, 64'h0,   1, 1, 64'h108, 1, 1, 64'h100);
      v(0, 0, 64'h0,   1, 1, 64'h10C, 1, 1, 64'h104);
      v(0, 1, 64'h203, 1, 0, 64'h110, 1, 1, 64'h108);  // redirect + pop, misaligned
      v(0, 0, 64'h0,   1, 1, 64'h200, 0, 0, 64'h0);
      v(0, 0, 64'h0,   1, 1, 64'h204, 0, 0, 64'h0);
      v(0, 0, 64'h0,   1, 1, 64'h208, 1, 1, 64'h200);
      v(0, 1, 64'h300, 1, 0, 64'h20C, 1, 1, 64'h204); // back-to-back redirects
      v(0, 1, 64'h400, 1, 0, 64'h300, 0, 0, 64'h0);
      v(0, 0, 64'h0,   1, 1, 64'h400, 0, 0, 64'h0);
      v(0, 0, 64'h0,   1, 1, 64'h404, 0, 0, 64'h0);
      v(0, 0, 64'h0,   1, 1, 64'h408, 1, 1, 64'h400);
      v(1, 0, 64'h0,   1, 0, 64'h40C, 1, 1, 64'h404); // reset mid-operation
      v(0, 0, 64'h0,   1, 1, 64'h0,   0, 1, 64'h0);
      v(0, 0, 64'h0,   1, 1, 64'h4,   0, 1, 64'h0);
      v(0, 0, 64'h0,   1, 1, 64'h8,   1, 1, 64'h0);

      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < tbl.size(); i++) begin
         reset = tbl[i].rst; redirect = tbl[i].rdr;
         redirect_pc = tbl[i].rpc; f_ready = tbl[i].rdy;
         @(negedge clk);
         chk($sformatf("row%0d_req", i), 64'(imem_req), 64'(tbl[i].e_req));
         chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].e_addr);
         chk($sformatf("row%0d_valid", i), 64'(f_valid), 64'(tbl[i].e_vld));
         if (tbl[i].hd) begin
            chk($sformatf("row%0d_pc", i), f_pc, tbl[i].e_pc);
            chk($sformatf("row%0d_instr", i), 64'(f_instr),
                tbl[i].e_vld ? 64'(mem_word(tbl[i].e_pc)) : 64'h0);
         end
         @(posedge clk);
         #1;
      end

      // Random backpressure against an occupancy model of the issue rule.
      redirect = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      q = 0; inf = 0; exp_pc = 64'h0; pops = 0;
      for (int c = 0; c < 300; c++) begin
         f_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         popped  = f_valid && f_ready;
         exp_req = (q + inf - (popped ? 1 : 0)) < 2;
         chk("rand_valid", 64'(f_valid), 64'(q > 0));
         chk("rand_req", 64'(imem_req), 64'(exp_req));
         if (f_valid) begin
            chk("rand_pc", f_pc, exp_pc);
            chk("rand_instr", 64'(f_instr), 64'(mem_word(exp_pc)));
         end
         if (popped) begin
            exp_pc = exp_pc + 64'd4;
            pops++;
         end
         q   = q + inf - (popped ? 1 : 0);
         inf = exp_req ? 1 : 0;
         @(posedge clk); #1;
      end
      chk("rand_progress", 64'(pops > 50), 64'h1);

      // PC wrap at the top of the address space.
      f_ready = 1'b1; redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      @(posedge clk); #1;
      redirect = 1'b0;
      wait_cnt = 0;
      @(negedge clk);
      while (!f_valid && wait_cnt < 10) begin
         @(negedge clk);
         wait_cnt++;
      end
      chk("wrap_timeout", 64'(f_valid), 64'h1);
      chk("wrap_pc_hi", f_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_instr_hi", 64'(f_instr), 64'h9FFF_FFFF);
      @(negedge clk);
      chk("wrap_valid_lo", 64'(f_valid), 64'h1);
      chk("wrap_pc_lo", f_pc, 64'h0);
      chk("wrap_instr_lo", 64'(f_instr), 64'hA000_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
